// File: rtl/xs_result_serializer.sv
// xs_result_serializer
// Buffers 8-bit result words in a small FIFO and sends each one as a framed
// serial word: start bit (0), 8 data bits MSB first, optional even-parity
// bit, stop bit (1). Every bit is held for CLKS_PER_BIT clock cycles.
// Optional feature macro: XS_SER_PARITY_EN (adds the PARITY bit, 11-bit frame);
// without it the frame is 10 bits.
module xs_result_serializer #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ser_out,
  output logic       ser_frame,
  output logic [3:0] fifo_count,
  output logic       err_drop
);

  localparam int         PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C  = 4'(DEPTH);
  localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);

`ifdef XS_SER_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;
`endif

  // Even parity over a data word.
  function automatic logic even_parity(input logic [7:0] w);
    return ^w;
  endfunction

  // Rotate left by one. Rotating (rather than shifting) keeps the original
  // word recoverable after 8 bits, so the parity bit needs no extra storage.
  function automatic logic [7:0] rotl8(input logic [7:0] w);
    return {w[6:0], w[7]};
  endfunction

  // FIFO storage and control
  logic [7:0]       fifo_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       count_q, count_d;
  logic             err_drop_q, err_drop_d;
  logic             push;
  logic             drop;
  logic             pop;
  logic [7:0]       head;

  // Serializer state
  state_t     state_q, state_d;
  logic [7:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       ser_out_q, ser_out_d;
  logic       ser_frame_q, ser_frame_d;
  logic       bit_done;

  // Full is the only back-pressure condition; a full FIFO never accepts,
  // even when the serializer pops on the same edge.
  assign in_ready = (count_q != DEPTH_C);
  assign push     = in_valid & in_ready;
  assign drop     = in_valid & ~in_ready;
  assign head     = fifo_mem_q[rd_ptr_q];
  assign bit_done = (bit_cnt_q == BIT_LAST);

  assign ser_out    = ser_out_q;
  assign ser_frame  = ser_frame_q;
  assign fifo_count = count_q;
  assign err_drop   = err_drop_q;

  // Word storage: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointer, occupancy and sticky drop-flag next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_drop_d = err_drop_q | drop;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // Frame sequencing: bit-period timing, bit index and head-of-FIFO pops.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 8'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (count_q != 4'd0) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          shift_d   = rotl8(shift_q);
          if (bit_idx_q == 3'd7) begin
`ifdef XS_SER_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef XS_SER_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          // Chain straight into the next frame so queued words go out
          // without an idle bit between them.
          if (count_q != 4'd0) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // Line outputs decoded from the next state so they are registered
  // together with the state they belong to.
  always_comb begin
    ser_out_d   = 1'b1;
    ser_frame_d = 1'b1;
    case (state_d)
      IDLE:    ser_frame_d = 1'b0;
      START:   ser_out_d   = 1'b0;
      DATA:    ser_out_d   = shift_d[7];
`ifdef XS_SER_PARITY_EN
      PARITY:  ser_out_d   = even_parity(shift_d);
`endif
      STOP:    ser_out_d   = 1'b1;
      default: ser_frame_d = 1'b0;
    endcase
  end

  // State registers; reset aborts any frame and empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_drop_q  <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      ser_out_q   <= 1'b1;
      ser_frame_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_drop_q  <= err_drop_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      ser_out_q   <= ser_out_d;
      ser_frame_q <= ser_frame_d;
    end
  end

endmodule

// File: tb/tb_xs_result_serializer.sv
// Testbench for xs_result_serializer. Two instances share the clock and reset:
// lane 0 with CLKS_PER_BIT=1, lane 1 with CLKS_PER_BIT=4. Stimulus queues the
// expected serial waveform of every frame; a monitor checks each frame as it
// appears on the line.
module tb_xs_result_serializer;

  localparam int DEPTH = 4;
  localparam int CPB_T [2] = '{1, 4};
`ifdef XS_SER_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // wave[0] is the start bit, the remaining bits follow in line order.
  typedef struct {
    int          lane;
    logic [10:0] wave;
    bit          b2b;
    bit          abort;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data    [2];
  logic       in_valid   [2];
  logic       in_ready   [2];
  logic       ser_out    [2];
  logic       ser_frame  [2];
  logic [3:0] fifo_count [2];
  logic       err_drop   [2];

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q [$];

  // Monitor state per lane
  bit          in_frame [2];
  bit          have     [2];
  bit          bad      [2];
  int          cyc      [2];
  int          gap      [2];
  logic [10:0] obs      [2];
  exp_t        cur      [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    xs_result_serializer #(
      .DEPTH       (DEPTH),
      .CLKS_PER_BIT(CPB_T[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .ser_out   (ser_out[g]),
      .ser_frame (ser_frame[g]),
      .fifo_count(fifo_count[g]),
      .err_drop  (err_drop[g])
    );
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [10:0] wave_of(input logic [7:0] d);
    logic [10:0] w;
    w    = '1;
    w[0] = 1'b0;
    for (int i = 0; i < 8; i++) w[1+i] = d[7-i];
`ifdef XS_SER_PARITY_EN
    w[9] = ^d;
`endif
    return w;
  endfunction

  task automatic expect_frame(input int lane, input logic [10:0] wave, input bit b2b, input bit abort);
    exp_t e;
    e.lane  = lane;
    e.wave  = wave;
    e.b2b   = b2b;
    e.abort = abort;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      tick();
      if (exp_q.size() == 0 && !in_frame[0] && !in_frame[1] &&
          ser_frame[0] === 1'b0 && ser_frame[1] === 1'b0)
        done = 1'b1;
    end
    check({"drain_", tag}, 32'(done), 32'd1);
  endtask

  // Monitor: checks every cycle of every frame against the queued waveform.
  initial begin
    for (int l = 0; l < 2; l++) begin
      in_frame[l] = 1'b0;
      have[l]     = 1'b0;
      bad[l]      = 1'b0;
      cyc[l]      = 0;
      gap[l]      = 1;
      obs[l]      = '0;
    end
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        int full;
        int b;
        full = FRAME_BITS * CPB_T[l];
        if (!in_frame[l] && ser_frame[l] === 1'b1) begin
          in_frame[l] = 1'b1;
          cyc[l]      = 0;
          bad[l]      = 1'b0;
          obs[l]      = '0;
          if (exp_q.size() != 0 && exp_q[0].lane == l) begin
            cur[l]  = exp_q.pop_front();
            have[l] = 1'b1;
            if (cur[l].b2b) check($sformatf("gap_lane%0d", l), gap[l], 0);
          end else begin
            have[l] = 1'b0;
            checks++;
            errors++;
            $display("FAIL unexpected_frame lane%0d: frame started, none required", l);
          end
        end
        if (in_frame[l]) begin
          if (ser_frame[l] !== 1'b1) begin
            in_frame[l] = 1'b0;
            gap[l]      = 1;
            if (have[l]) begin
              if (cur[l].abort) begin
                check($sformatf("abort_cut_lane%0d", l), 32'(cyc[l] < full), 32'd1);
              end else begin
                checks++;
                errors++;
                $display("FAIL frame_len lane%0d: ser_frame high %0d cycles, required %0d",
                         l, cyc[l], full);
              end
            end
          end else begin
            b = cyc[l] / CPB_T[l];
            if (cyc[l] % CPB_T[l] == 0) obs[l][b] = ser_out[l];
            if (have[l] && ser_out[l] !== cur[l].wave[b]) bad[l] = 1'b1;
            cyc[l]++;
            if (cyc[l] == full) begin
              in_frame[l] = 1'b0;
              gap[l]      = 0;
              if (have[l]) begin
                checks++;
                if (bad[l] || cur[l].abort) begin
                  errors++;
                  $display("FAIL frame lane%0d: line bits (start at right) %b required %b abort=%0d",
                           l, obs[l][FRAME_BITS-1:0], cur[l].wave[FRAME_BITS-1:0], cur[l].abort);
                end
              end
            end
          end
        end else if (ser_frame[l] !== 1'b1) begin
          gap[l]++;
        end
      end
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "time limit");
  end

  // Directed stimulus
  initial begin
    rst_n = 1'b0;
    for (int l = 0; l < 2; l++) begin
      in_data[l]  = 8'h00;
      in_valid[l] = 1'b0;
    end
    @(negedge clk);
    ticks(2);
    for (int l = 0; l < 2; l++) begin
      check($sformatf("rst_ser_out_l%0d", l),   32'(ser_out[l]),    32'd1);
      check($sformatf("rst_ser_frame_l%0d", l), 32'(ser_frame[l]),  32'd0);
      check($sformatf("rst_count_l%0d", l),     32'(fifo_count[l]), 32'd0);
      check($sformatf("rst_err_drop_l%0d", l),  32'(err_drop[l]),   32'd0);
      check($sformatf("rst_in_ready_l%0d", l),  32'(in_ready[l]),   32'd1);
    end
    rst_n = 1'b1;
    tick();

    // Single word 0x66, one bit per cycle; line 0,0,1,1,0,0,1,1,0,1.
`ifdef XS_SER_PARITY_EN
    expect_frame(0, wave_of(8'h66), 1'b0, 1'b0);
`else
    expect_frame(0, 11'b11011001100, 1'b0, 1'b0);
`endif
    in_data[0]  = 8'h66;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    check("e0_count",     32'(fifo_count[0]), 32'd1);
    check("e0_ser_frame", 32'(ser_frame[0]),  32'd0);
    tick();
    check("e1_ser_frame", 32'(ser_frame[0]),  32'd1);
    check("e1_ser_out",   32'(ser_out[0]),    32'd0);
    check("e1_count",     32'(fifo_count[0]), 32'd0);
    wait_idle("x66", 40);
    check("x66_idle_out",   32'(ser_out[0]),   32'd1);
    check("x66_idle_frame", 32'(ser_frame[0]), 32'd0);

    // 0x55 then 0xAA on consecutive edges: second frame starts right after STOP.
    expect_frame(0, wave_of(8'h55), 1'b0, 1'b0);
    expect_frame(0, wave_of(8'hAA), 1'b1, 1'b0);
    in_data[0]  = 8'h55;
    in_valid[0] = 1'b1;
    tick();
    in_data[0]  = 8'hAA;
    tick();
    in_valid[0] = 1'b0;
    check("b2b_count", 32'(fifo_count[0]), 32'd1);
    wait_idle("b2b", 60);

`ifdef XS_SER_PARITY_EN
    // 0xE6 -> 0,1,1,1,0,0,1,1,0,1,1 ; 0xCC -> parity 0.
    expect_frame(0, 11'b11011001110, 1'b0, 1'b0);
    in_data[0]  = 8'hE6;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    wait_idle("xe6", 40);
    expect_frame(0, 11'b10001100110, 1'b0, 1'b0);
    in_data[0]  = 8'hCC;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    wait_idle("xcc", 40);
`endif

    // Lane 1 (4 clocks/bit): 0x01..0x06 on six edges, sixth is dropped.
    begin
      int exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
      for (int i = 0; i < 6; i++) begin
        if (i < 5) expect_frame(1, wave_of(8'(i + 1)), i > 0, 1'b0);
        in_data[1]  = 8'(i + 1);
        in_valid[1] = 1'b1;
        if (i == 5) check("fill_in_ready_low", 32'(in_ready[1]), 32'd0);
        tick();
        check($sformatf("fill_count_%0d", i), 32'(fifo_count[1]), 32'(exp_cnt[i]));
      end
      in_valid[1] = 1'b0;
      check("fill_err_drop", 32'(err_drop[1]), 32'd1);
    end
    wait_idle("fill", 400);

    // Offer while full on the STOP edge that pops: word dropped, count DEPTH-1.
    do_reset();
    check("full_pop_err_clear", 32'(err_drop[1]), 32'd0);
    begin
      logic [7:0] w [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h88};
      for (int i = 0; i < 5; i++) begin
        expect_frame(1, wave_of(w[i]), i > 0, 1'b0);
        in_data[1]  = w[i];
        in_valid[1] = 1'b1;
        tick();
      end
      in_valid[1] = 1'b0;
    end
    ticks(FRAME_BITS * 4 - 4);
    check("full_pop_count_before", 32'(fifo_count[1]), 32'd4);
    check("full_pop_in_ready",     32'(in_ready[1]),   32'd0);
    check("full_pop_err_before",   32'(err_drop[1]),   32'd0);
    in_data[1]  = 8'h99;
    in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    check("full_pop_err_after",   32'(err_drop[1]),   32'd1);
    check("full_pop_count_after", 32'(fifo_count[1]), 32'(DEPTH - 1));
    wait_idle("full_pop", 400);

    // Reset during the 4th data bit of 0xA1 with two words still queued.
    do_reset();
    expect_frame(1, wave_of(8'hA1), 1'b0, 1'b1);
    in_data[1]  = 8'hA1;
    in_valid[1] = 1'b1;
    tick();
    in_data[1]  = 8'hB2;
    tick();
    in_data[1]  = 8'hC3;
    tick();
    in_valid[1] = 1'b0;
    ticks(15);
    check("abort_pre_frame", 32'(ser_frame[1]),  32'd1);
    check("abort_pre_count", 32'(fifo_count[1]), 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ser_out",   32'(ser_out[1]),    32'd1);
    check("abort_ser_frame", 32'(ser_frame[1]),  32'd0);
    check("abort_count",     32'(fifo_count[1]), 32'd0);
    check("abort_err_drop",  32'(err_drop[1]),   32'd0);
    ticks(80);
    check("abort_quiet_frame", 32'(ser_frame[1]),  32'd0);
    check("abort_quiet_count", 32'(fifo_count[1]), 32'd0);
    check("abort_no_frame",    32'(in_frame[1]),   32'd0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
